burst_arbiter: RTL

Bus arbiter between the eight peripheral RX FIFOs and the lycan-to-FTDI output FIFO. Each cycle it decides which peripheral may push 32-bit packets toward USB, holds that grant for a bounded burst, and generates the one-hot `rx_read` pops. It gives priority to peripherals whose RX FIFO is almost full and stalls on output-FIFO backpressure. `grant` drives the packet/valid muxes; `rx_read` replaces the external `decoded_grant & ~rx_fifo_empty` gating.

---
 rtl/burst_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/burst_arbiter.sv
// Arbitrates the peripheral RX FIFOs onto the shared output FIFO: one bounded burst per grant,
// round-robin fairness with almost-full peripherals taking precedence.
module burst_arbiter #(
   parameter int NUM_PERIPHS = 8,
   parameter int GRANT_WIDTH = 3,
   parameter int MAX_BURST   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PERIPHS-1:0] rx_fifo_empty,
   input  logic [NUM_PERIPHS-1:0] rx_fifo_almost_full,
   input  logic                   out_fifo_full,
   output logic [GRANT_WIDTH-1:0] grant,
   output logic                   grant_valid,
   output logic [NUM_PERIPHS-1:0] rx_read,
   output logic [7:0]             burst_count
);

   // state   | meaning
   // --------+-------------------------------------------------------------
   // S_IDLE  | no owner; pick a winner from urgent requests, else all requests
   // S_GRANT | grant owns the output FIFO; pops until empty, cap or preemption

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   localparam logic [7:0]             LAST_BEAT   = 8'(MAX_BURST - 1);
   localparam logic [GRANT_WIDTH-1:0] LAST_PERIPH = GRANT_WIDTH'(NUM_PERIPHS - 1);
   localparam logic [GRANT_WIDTH:0]   WRAP        = (GRANT_WIDTH + 1)'(NUM_PERIPHS);

   state_t                 state;
   state_t                 state_next;
   logic [GRANT_WIDTH-1:0] last_grant;
   logic [GRANT_WIDTH-1:0] last_grant_next;
   logic [GRANT_WIDTH-1:0] grant_next;
   logic [GRANT_WIDTH-1:0] winner;
   logic [7:0]             burst_count_next;
   logic                   grant_valid_next;

   logic [NUM_PERIPHS-1:0] req;
   logic [NUM_PERIPHS-1:0] urgent;
   logic [NUM_PERIPHS-1:0] cand;
   logic [NUM_PERIPHS-1:0] grant_mask;
   logic                   any_req;
   logic                   any_urgent;
   logic                   winner_found;
   logic                   read_ok;
   logic                   preempt;

   assign req        = ~rx_fifo_empty;
   assign urgent     = req & rx_fifo_almost_full;
   assign any_req    = |req;
   assign any_urgent = |urgent;
   assign cand       = any_urgent ? urgent : req;
   assign grant_mask = {{(NUM_PERIPHS-1){1'b0}}, 1'b1} << grant;

   // Another peripheral about to overflow takes the bus unless the owner is itself urgent.
   assign preempt    = ~urgent[grant] & (|(urgent & ~grant_mask));

   // Rotating scan starting just after the previous winner, wrapping at NUM_PERIPHS.
   always_comb begin : pick_winner
      logic [GRANT_WIDTH:0] idx;
      idx          = '0;
      winner       = last_grant;
      winner_found = 1'b0;
      for (int k = 1; k <= NUM_PERIPHS; k++) begin
         idx = {1'b0, last_grant} + (GRANT_WIDTH + 1)'(k);
         if (idx >= WRAP) begin
            idx = idx - WRAP;
         end
         if (!winner_found && cand[idx[GRANT_WIDTH-1:0]]) begin
            winner       = idx[GRANT_WIDTH-1:0];
            winner_found = 1'b1;
         end
      end
   end

   always_comb begin : fsm_next
      state_next       = state;
      grant_next       = grant;
      last_grant_next  = last_grant;
      burst_count_next = burst_count;
      rx_read          = '0;
      read_ok          = 1'b0;

      case (state)
         S_IDLE: begin
            if (any_req) begin
               state_next       = S_GRANT;
               grant_next       = winner;
               last_grant_next  = winner;
               burst_count_next = '0;
            end
         end

         S_GRANT: begin
            read_ok = ~rx_fifo_empty[grant] & ~out_fifo_full;
            if (read_ok) begin
               rx_read          = grant_mask;
               burst_count_next = burst_count + 8'd1;
            end
            // The pop in an exit cycle still happens; grant holds through the following idle cycle.
            if (rx_fifo_empty[grant]) begin
               state_next = S_IDLE;
            end else if (read_ok && (burst_count == LAST_BEAT)) begin
               state_next = S_IDLE;
            end else if (preempt) begin
               state_next = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign grant_valid_next = (state_next == S_GRANT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         last_grant  <= LAST_PERIPH;
         burst_count <= '0;
      end else begin
         state       <= state_next;
         grant       <= grant_next;
         grant_valid <= grant_valid_next;
         last_grant  <= last_grant_next;
         burst_count <= burst_count_next;
      end
   end

endmodule
